// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and default ALU pipeline latency for the ALU issue controller.
// No logic here: pure declarations, no latency, no backpressure.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_DEC = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int ALU_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WB
  } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x DATA_W register file, r0 reads zero and drops writes; two operand ports plus a debug port.
// Reads are combinational (zero latency), one write per edge, async clear; never stalls.
module alu_seq_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [IDX_W-1:0]  dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
  assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issues rd = rs1 op rs2 to a registered ALU and writes back after ALU_LAT+1 edges; accepts only when idle.
// Throughput one instruction per ALU_LAT+2 cycles. ALU_SEQ_OP_CHECK_EN rejects op 111 with an err pulse.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 8,
  parameter int ALU_LAT = ALU_LAT_DEFAULT,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [IDX_W-1:0]  in_rs1,
  input  logic [IDX_W-1:0]  in_rs2,
  input  logic              host_we,
  input  logic [IDX_W-1:0]  host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [IDX_W-1:0]  dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_Y,
  input  logic              alu_Zero,
  input  logic              alu_Cout,
  input  logic              alu_Borrow,
  output logic              flag_zero,
  output logic              flag_cout,
  output logic              flag_borrow,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] rs1_dat, rs2_dat;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic              op_ill;

`ifdef ALU_SEQ_OP_CHECK_EN
  assign op_ill = (in_op == OP_ILL);
`else
  assign op_ill = 1'b0;
`endif

  assign in_ready = (state == ST_IDLE);

  // Writeback owns the single write port in WB; the host may only use it while idle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = host_waddr;
    wr_dat  = host_wdata;
    if (state == ST_WB) begin
      wr_en   = 1'b1;
      wr_addr = rd_q;
      wr_dat  = alu_Y;
    end else if (state == ST_IDLE) begin
      wr_en = host_we;
    end
  end

  alu_seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .we        (wr_en),
    .waddr     (wr_addr),
    .wdata     (wr_dat),
    .raddr_a   (in_rs1),
    .rdata_a   (rs1_dat),
    .raddr_b   (in_rs2),
    .rdata_b   (rs2_dat),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_sel     <= OP_ADD;
      flag_zero   <= 1'b0;
      flag_cout   <= 1'b0;
      flag_borrow <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && op_ill) begin
            err <= 1'b1;
          end else if (in_valid) begin
            alu_A   <= rs1_dat;
            alu_B   <= rs2_dat;
            alu_sel <= in_op;
            rd_q    <= in_rd;
            cnt     <= CNT_W'(ALU_LAT);
            state   <= ST_WAIT;
          end
        end
        // Counter reaching 1 means the ALU output has just updated; sample it on the next edge.
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= ST_WB;
        end
        ST_WB: begin
          flag_zero   <= alu_Zero;
          flag_cout   <= alu_Cout;
          flag_borrow <= alu_Borrow;
          done        <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural two-stage registered ALU attached.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int IDX_W  = 3;

  logic              Clock, Reset_n;
  logic              in_valid, in_ready;
  logic [2:0]        in_op;
  logic [IDX_W-1:0]  in_rd, in_rs1, in_rs2;
  logic              host_we;
  logic [IDX_W-1:0]  host_waddr;
  logic [DATA_W-1:0] host_wdata;
  logic [IDX_W-1:0]  dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic [DATA_W-1:0] alu_A, alu_B, alu_Y;
  logic [2:0]        alu_sel;
  logic              alu_Zero, alu_Cout, alu_Borrow;
  logic              flag_zero, flag_cout, flag_borrow, done, err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_seq_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS), .ALU_LAT(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel),
    .alu_Y(alu_Y), .alu_Zero(alu_Zero), .alu_Cout(alu_Cout), .alu_Borrow(alu_Borrow),
    .flag_zero(flag_zero), .flag_cout(flag_cout), .flag_borrow(flag_borrow),
    .done(done), .err(err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Registered ALU: captures inputs on one edge, updates outputs on the next.
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        s_q;
  logic [DATA_W:0]   wide;

  always @(posedge Clock) begin
    a_q <= alu_A;
    b_q <= alu_B;
    s_q <= alu_sel;
  end

  always_comb begin
    wide = '0;
    case (s_q)
      OP_ADD:  wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  wide = {1'b0, a_q - b_q};
      OP_AND:  wide = {1'b0, a_q & b_q};
      OP_OR:   wide = {1'b0, a_q | b_q};
      OP_XOR:  wide = {1'b0, a_q ^ b_q};
      OP_INC:  wide = {1'b0, a_q} + 33'd1;
      OP_DEC:  wide = {1'b0, a_q - 32'd1};
      OP_ILL:  wide = '0;
      default: wide = '0;
    endcase
  end

  always @(posedge Clock) begin
    alu_Y      <= wide[DATA_W-1:0];
    alu_Cout   <= wide[DATA_W];
    alu_Zero   <= (wide[DATA_W-1:0] == '0);
    alu_Borrow <= (s_q == OP_SUB) ? (a_q < b_q) : (s_q == OP_DEC) ? (a_q == '0) : 1'b0;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic peek(input logic [IDX_W-1:0] idx);
    dbg_raddr = idx;
    #1;
  endtask

  task automatic host_write(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [IDX_W-1:0] rd,
                       input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    host_we = 0; host_waddr = 0; host_wdata = 0; dbg_raddr = 1;
    #22;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({done, err} !== 2'b00) $display("FAIL reset_done_err: got %b want 00", {done, err}); else pass_cnt++;
    chk_cnt++; if ({flag_zero, flag_cout, flag_borrow} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {flag_zero, flag_cout, flag_borrow}); else pass_cnt++;
    chk_cnt++; if ({alu_A, alu_B, alu_sel} !== '0) $display("FAIL reset_alu: got %h %h %b want 0", alu_A, alu_B, alu_sel); else pass_cnt++;
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL reset_r1: got %h want 0", dbg_rdata); else pass_cnt++;
    @(negedge Clock); Reset_n = 1'b1;
    tick();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    host_write(1, 32'hFFFF_FFFF);
    host_write(2, 32'h1);
    host_write(3, 32'h1234);
    issue(OP_ADD, 3, 1, 2);
    chk_cnt++; if ({alu_A, alu_B, alu_sel} !== {32'hFFFF_FFFF, 32'h1, OP_ADD}) $display("FAIL add_alu_in: got %h %h %b", alu_A, alu_B, alu_sel); else pass_cnt++;
    tick();
    chk_cnt++; if ({done, in_ready} !== 2'b00) $display("FAIL add_e1: got done/ready %b want 00", {done, in_ready}); else pass_cnt++;
    tick();
    chk_cnt++; if ({done, in_ready} !== 2'b00) $display("FAIL add_e2: got done/ready %b want 00", {done, in_ready}); else pass_cnt++;
    tick();
    chk_cnt++; if ({done, in_ready} !== 2'b11) $display("FAIL add_e3: got done/ready %b want 11", {done, in_ready}); else pass_cnt++;
    chk_cnt++; if ({flag_zero, flag_cout, flag_borrow} !== 3'b110) $display("FAIL add_flags: got %b want 110", {flag_zero, flag_cout, flag_borrow}); else pass_cnt++;
    peek(3);
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL add_r3: got %h want 0", dbg_rdata); else pass_cnt++;
    tick();
    chk_cnt++; if (done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_sub();
    host_write(4, 32'd5);
    host_write(5, 32'd7);
    issue(OP_SUB, 6, 4, 5);
    tick(); tick(); tick();
    chk_cnt++; if (done !== 1'b1) $display("FAIL sub_done: got %b want 1", done); else pass_cnt++;
    chk_cnt++; if ({flag_zero, flag_cout, flag_borrow} !== 3'b001) $display("FAIL sub_flags: got %b want 001", {flag_zero, flag_cout, flag_borrow}); else pass_cnt++;
    peek(6);
    chk_cnt++; if (dbg_rdata !== 32'hFFFF_FFFE) $display("FAIL sub_r6: got %h want fffffffe", dbg_rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_op = OP_OR; in_rd = 7; in_rs1 = 4; in_rs2 = 5;
    for (int k = 0; k < 12; k++) begin
      logic exp_hi;
      tick();
      exp_hi = ((k % 4) == 3);
      chk_cnt++; if (in_ready !== exp_hi) $display("FAIL b2b_ready[%0d]: got %b want %b", k, in_ready, exp_hi); else pass_cnt++;
      chk_cnt++; if (done !== exp_hi) $display("FAIL b2b_done[%0d]: got %b want %b", k, done, exp_hi); else pass_cnt++;
      if (k == 3) begin in_op = OP_AND; in_rd = 1; end
      if (k == 7) begin in_op = OP_XOR; in_rd = 2; end
      if (k == 11) in_valid = 1'b0;
    end
    peek(7);
    chk_cnt++; if (dbg_rdata !== 32'd7) $display("FAIL b2b_or_r7: got %h want 7", dbg_rdata); else pass_cnt++;
    peek(1);
    chk_cnt++; if (dbg_rdata !== 32'd5) $display("FAIL b2b_and_r1: got %h want 5", dbg_rdata); else pass_cnt++;
    peek(2);
    chk_cnt++; if (dbg_rdata !== 32'd2) $display("FAIL b2b_xor_r2: got %h want 2", dbg_rdata); else pass_cnt++;
  endtask

  task automatic test_r0_and_host();
    host_we = 1'b1; host_waddr = 0; host_wdata = 32'h55;
    issue(OP_XOR, 0, 4, 5);
    host_we = 1'b1; host_waddr = 5; host_wdata = 32'hAA;
    tick(); tick(); tick();
    host_we = 1'b0;
    chk_cnt++; if (done !== 1'b1) $display("FAIL r0_done: got %b want 1", done); else pass_cnt++;
    peek(0);
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL r0_value: got %h want 0", dbg_rdata); else pass_cnt++;
    peek(5);
    chk_cnt++; if (dbg_rdata !== 32'd7) $display("FAIL busy_host_we: got %h want 7", dbg_rdata); else pass_cnt++;
    host_we = 1'b1; host_waddr = 4; host_wdata = 32'd9;
    issue(OP_ADD, 3, 4, 5);
    host_we = 1'b0;
    tick(); tick(); tick();
    peek(3);
    chk_cnt++; if (dbg_rdata !== 32'd12) $display("FAIL collide_no_bypass: got %h want c", dbg_rdata); else pass_cnt++;
    peek(4);
    chk_cnt++; if (dbg_rdata !== 32'd9) $display("FAIL collide_host_commit: got %h want 9", dbg_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    issue(OP_INC, 1, 1, 0);
    tick();
    Reset_n = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_idle: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (alu_A !== 32'h0) $display("FAIL midrst_alu_A: got %h want 0", alu_A); else pass_cnt++;
    peek(1);
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL midrst_r1_cleared: got %h want 0", dbg_rdata); else pass_cnt++;
    @(negedge Clock); Reset_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      done_seen |= done;
    end
    chk_cnt++; if (done_seen !== 1'b0) $display("FAIL midrst_no_done: got %b want 0", done_seen); else pass_cnt++;
    peek(1);
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL midrst_r1_after: got %h want 0", dbg_rdata); else pass_cnt++;
  endtask

  task automatic test_illegal_op();
    logic err_seen;
    host_write(3, 32'h77);
    host_write(4, 32'd3);
    host_write(5, 32'd4);
    issue(OP_ADD, 6, 4, 5);
    tick(); tick(); tick();
    issue(OP_ILL, 3, 5, 4);
`ifdef ALU_SEQ_OP_CHECK_EN
    chk_cnt++; if ({err, in_ready} !== 2'b11) $display("FAIL ill_err_idle: got err/ready %b want 11", {err, in_ready}); else pass_cnt++;
    chk_cnt++; if ({alu_A, alu_sel} !== {32'd3, OP_ADD}) $display("FAIL ill_alu_hold: got %h %b want 3 000", alu_A, alu_sel); else pass_cnt++;
    tick();
    chk_cnt++; if (err !== 1'b0) $display("FAIL ill_err_pulse: got %b want 0", err); else pass_cnt++;
    err_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      err_seen |= done;
    end
    chk_cnt++; if (err_seen !== 1'b0) $display("FAIL ill_no_done: got %b want 0", err_seen); else pass_cnt++;
    chk_cnt++; if (flag_zero !== 1'b0) $display("FAIL ill_flags_hold: got %b want 0", flag_zero); else pass_cnt++;
    peek(3);
    chk_cnt++; if (dbg_rdata !== 32'h77) $display("FAIL ill_rd_kept: got %h want 77", dbg_rdata); else pass_cnt++;
`else
    chk_cnt++; if (alu_sel !== OP_ILL) $display("FAIL ill_issued_sel: got %b want 111", alu_sel); else pass_cnt++;
    err_seen = err;
    tick(); err_seen |= err;
    tick(); err_seen |= err;
    tick(); err_seen |= err;
    chk_cnt++; if (done !== 1'b1) $display("FAIL ill_done: got %b want 1", done); else pass_cnt++;
    chk_cnt++; if (flag_zero !== 1'b1) $display("FAIL ill_flag_zero: got %b want 1", flag_zero); else pass_cnt++;
    chk_cnt++; if (err_seen !== 1'b0) $display("FAIL ill_err_tied: got %b want 0", err_seen); else pass_cnt++;
    peek(3);
    chk_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL ill_rd_zero: got %h want 0", dbg_rdata); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_r0_and_host();
    test_reset_mid();
    test_illegal_op();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Issue-side controller for the 32-bit registered ALU. It accepts three-operand instructions over a valid/ready handshake and reads the operands from a local register file. It drives the ALU's operand and select inputs, waits out the ALU's pipeline latency, then writes the result and flags back. It sits between the instruction front end (or testbench host) and the ALU, closing the loop the ALU leaves open.

## Interface
- `DATA_W`, 32: operand/result width
- `NREGS`, 8: register-file depth; index width `IDX_W = $clog2(NREGS)`
- `ALU_LAT`, 2: clock edges from ALU input capture to ALU output update; 2 matches the ALU
- `Clock` in 1: single clock, rising edge
- `Reset_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: instruction offered
- `in_ready` out 1: controller idle, instruction accepted when both high
- `in_op` in 3: ALU select code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 inc, 110 dec)
- `in_rd`, `in_rs1`, `in_rs2` in IDX_W: destination/source indices
- `host_we` in 1, `host_waddr` in IDX_W, `host_wdata` in DATA_W: register preload
- `dbg_raddr` in IDX_W, `dbg_rdata` out DATA_W: combinational register read
- `alu_A`, `alu_B` out DATA_W; `alu_sel` out 3: to ALU, registered
- `alu_Y` in DATA_W; `alu_Zero`, `alu_Cout`, `alu_Borrow` in 1: from ALU
- `flag_zero`, `flag_cout`, `flag_borrow` out 1: flags of last writeback
- `done` out 1: one-cycle pulse after each writeback
- `err` out 1: one-cycle pulse on rejected opcode (macro only)

## Operation
- FSM states: IDLE, WAIT, WB. `in_ready = (state == IDLE)`.
- IDLE: on `in_valid & in_ready`:
  - read `rs1`/`rs2` combinationally and register them into `alu_A`/`alu_B`, with `in_op` into `alu_sel`
  - latch `rd`, load the wait counter with `ALU_LAT`, go to WAIT
- WAIT: decrement the counter each edge; go to WB when it reaches 1.
- WB: at this edge, sample `alu_Y` and the three flags:
  - write `alu_Y` to `rd` unless `rd == 0`
  - update `flag_*`, assert `done` for the next cycle, return to IDLE
- Register 0 is hardwired zero. Reads return 0; writes to it by instruction or host are dropped.
- `host_we` is honoured only in IDLE. When busy it is ignored; the host must gate it on `in_ready`.
- If `host_we` coincides with an instruction accept in IDLE, the host write commits and the operand read sees the pre-write value (no bypass).
- `alu_A`/`alu_B`/`alu_sel` hold their values outside the accept edge.

## Timing
- Accept edge e0: ALU inputs valid after e0. The ALU captures at e1 and its output updates at e(ALU_LAT).
- Writeback edge: e(ALU_LAT+1), i.e. e3 at default.
- `done` is high in cycle e3–e4. `in_ready` rises after e3. Next accept is at e4 earliest.
- Throughput is one instruction per ALU_LAT+2 cycles.
- `in_*` must be stable only on the accept edge.
- Reset values: all registers 0; `alu_A`/`alu_B` 0; `alu_sel` 000; `flag_*` 0; `done`/`err` 0; state IDLE, so `in_ready` is 1 once `Reset_n` deasserts.
- Reset mid-operation: asynchronous return to IDLE. The pending writeback is discarded, the register file is cleared, and no `done` pulse is produced.

## Configuration
- `ALU_SEQ_OP_CHECK_EN` defined:
  - `in_op == 3'b111` is accepted but not issued
  - `alu_*` outputs are unchanged, no writeback, flags unchanged
  - `err` pulses in the cycle after the accept edge, and the state stays IDLE
- Not defined:
  - 111 is issued like any other opcode
  - the ALU returns 0, so `rd` is written with 0 and `flag_zero` becomes 1
  - `err` is tied 0

## Structure
- Shared package `alu_seq_pkg`:
  - op-code localparams (`OP_ADD`…`OP_DEC`, `OP_ILL`)
  - FSM state enum typedef
  - default `ALU_LAT`
- Sub-module `alu_seq_regfile`: NREGS×DATA_W, two combinational read ports plus a debug read port, one write port, r0 forced zero, async clear.
- Top-level contains the FSM, the counter, and the ALU-facing registers.
- The bench instantiates `alu_seq_ctrl` with the ALU.

## Test plan
1. Reset, preload r1=0xFFFF_FFFF and r2=1, then issue add r3=r1+r2. Expect r3=0, `flag_cout`=1, `flag_zero`=1, `done` at e3+1.
2. Preload r4=5 and r5=7, then issue sub r6=r4-r5. Expect r6=0xFFFF_FFFE, `flag_borrow`=1, `flag_cout`=0.
3. Hold `in_valid` continuously on back-to-back instructions. Expect accepts spaced exactly 4 cycles apart and `in_ready` low during WAIT/WB.
4. Issue xor with rd=0, and `host_we` to r0 with 0x55. Expect `dbg_rdata`(0)=0 and `done` still pulses.
5. Drop `Reset_n` during WAIT of inc r1. Expect immediate IDLE, r1=0, and no `done`.
6. Issue op 111, once with `ALU_SEQ_OP_CHECK_EN` defined and once without. Expect an `err` pulse with rd unchanged when defined; expect rd=0 and `flag_zero`=1 when not defined.
